btn_input_conditioner: RTL
==========================

// Module: btn_input_conditioner
// PURPOSE
//  Front-end stage feeding top_ALU: synchronises raw board switches/buttons, debounces each
//  button, and emits one single-cycle load pulse per physical press together with a switch
//  snapshot captured in the same cycle. top_ALU consumes o_load_pulse[2:0] (A, B, OPCODE)
//  and o_switches in place of the raw switches/botones.
// PARAMETERS
//  NB_SW            8       switch bus width
//  NB_BTN           3       number of buttons; bit0=LOAD_A, bit1=LOAD_B, bit2=LOAD_OPCODE
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles required to accept a level change (>=2)
//  NB_CNT           $clog2(DEBOUNCE_CYCLES)+1  debounce counter width (derived, localparam)
// PORTS
//  clock          in   1       system clock, all logic on rising edge
//  reset          in   1       asynchronous, active-high; clears every register below
//  i_switches     in   NB_SW   raw switches, asynchronous to clock
//  i_botones      in   NB_BTN  raw buttons, asynchronous, bouncing, active-high
//  o_switches     out  NB_SW   switch snapshot taken in the cycle o_load_pulse asserts
//  o_load_pulse   out  NB_BTN  one-hot-or-zero, one-cycle press pulses
//  o_btn_level    out  NB_BTN  debounced button levels
//  o_collision    out  1       one-cycle flag: >1 button qualified in same cycle
// BEHAVIOUR
//  - Sync: i_switches and i_botones each pass a 2-FF synchroniser (reset value 0).
//  - Debounce per button i: register db[i] (reset 0), counter cnt[i] (reset 0).
//    sync[i]==db[i] -> cnt[i]<=0. sync[i]!=db[i] -> cnt[i]<=cnt[i]+1; when cnt[i]==DEBOUNCE_CYCLES-1
//    db[i]<=sync[i], cnt[i]<=0. Shorter glitches never change db[i]; no wrap possible.
//  - rise[i] = db[i] & ~db_d[i] (db_d = db delayed 1 cycle, reset 0). Falling edges give no pulse.
//  - Arbitration: if rise has >1 bit set, only the lowest index pulses; the others are dropped
//    (no deferred pulse; user must release and re-press). o_collision=1 that same cycle.
//  - Outputs registered: o_load_pulse<=arbitrated rise; o_switches<=sync switches when any rise,
//    else hold. o_btn_level<=db. Reset values: all outputs 0.
//  - Latency: raw edge stable from cycle 0 -> sync valid cycle 2 -> db changes cycle
//    2+DEBOUNCE_CYCLES -> o_load_pulse high for exactly cycle 3+DEBOUNCE_CYCLES (+/-1 for
//    sampling phase of the async edge).
//  - Holding a button: exactly one pulse; o_btn_level stays 1 until a debounced release.
//  - Switch changes while no rise: o_switches unchanged (stable operand for top_ALU).
//  - Reset mid-debounce: counters, db, db_d, outputs cleared immediately; a button held
//    through reset deassertion is re-debounced and produces one fresh pulse.
//  - Reset asserted during a pulse cycle: pulse cleared asynchronously, not re-issued.
// TESTING (bench overrides DEBOUNCE_CYCLES=4)
//  1 Reset: reset=1, random inputs -> all outputs 0; release, inputs 0 for 20 cycles -> no pulse.
//  2 Clean press: i_switches=8'hA5, i_botones=3'b001 held 20 cycles -> o_load_pulse=3'b001 one
//    cycle at cycle 7 after edge (+/-1), o_switches=8'hA5, o_btn_level[0]=1 until release.
//  3 Bounce: i_botones[1] toggles 1/0 every 2 cycles for 12 cycles then stays 1 -> no pulse
//    during bounce, exactly one 3'b010 pulse after 4 stable cycles + sync latency.
//  4 Snapshot hold: after pulse with sw=8'h3C change i_switches to 8'hFF, no button ->
//    o_switches stays 8'h3C.
//  5 Collision: i_botones 3'b000->3'b110 in one cycle -> single pulse 3'b010, o_collision=1 same
//    cycle; no 3'b100 pulse while held.
//  6 Reset mid-operation: press btn2, assert reset after 2 stable cycles, release reset while
//    still held -> no pulse before reset, one 3'b100 pulse ~7 cycles after reset release.

Source files
------------

// File: rtl/btn_input_conditioner.sv
// Input conditioner for top_ALU: synchronises switches and buttons, debounces each button,
// and emits one arbitrated load pulse per press together with a switch snapshot.
module btn_input_conditioner #(
    parameter int unsigned NB_SW           = 8,
    parameter int unsigned NB_BTN          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NB_SW-1:0]  i_switches,
    input  logic [NB_BTN-1:0] i_botones,
    output logic [NB_SW-1:0]  o_switches,
    output logic [NB_BTN-1:0] o_load_pulse,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic              o_collision
);

    localparam int unsigned NB_CNT = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    logic [NB_SW-1:0]  sw_meta_q,    sw_meta_d;
    logic [NB_SW-1:0]  sw_sync_q,    sw_sync_d;
    logic [NB_BTN-1:0] btn_meta_q,   btn_meta_d;
    logic [NB_BTN-1:0] btn_sync_q,   btn_sync_d;
    logic [NB_BTN-1:0] db_q,         db_d;
    logic [NB_BTN-1:0] db_dly_q,     db_dly_d;
    logic [NB_CNT-1:0] cnt_q [NB_BTN];
    logic [NB_CNT-1:0] cnt_d [NB_BTN];
    logic [NB_SW-1:0]  switches_q,   switches_d;
    logic [NB_BTN-1:0] load_pulse_q, load_pulse_d;
    logic [NB_BTN-1:0] btn_level_q,  btn_level_d;
    logic              collision_q,  collision_d;

    logic [NB_BTN-1:0] rise_c;
    logic [NB_BTN-1:0] grant_c;

    // Synchronisers and per-button debounce counters
    always_comb begin
        sw_meta_d  = i_switches;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = i_botones;
        btn_sync_d = btn_meta_q;
        db_d       = db_q;
        db_dly_d   = db_q;
        cnt_d      = cnt_q;
        for (int i = 0; i < int'(NB_BTN); i++) begin
            if (btn_sync_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i] = '0;
                db_d[i]  = btn_sync_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + NB_CNT'(1);
            end
        end
    end

    // Rising edges; the lowest-index button wins, the rest are dropped
    always_comb begin
        rise_c       = db_q & ~db_dly_q;
        grant_c      = rise_c & (~rise_c + NB_BTN'(1));
        load_pulse_d = grant_c;
        collision_d  = |(rise_c & (rise_c - NB_BTN'(1)));
        switches_d   = (|rise_c) ? sw_sync_q : switches_q;
        btn_level_d  = db_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            db_q         <= '0;
            db_dly_q     <= '0;
            for (int i = 0; i < int'(NB_BTN); i++) begin
                cnt_q[i] <= '0;
            end
            switches_q   <= '0;
            load_pulse_q <= '0;
            btn_level_q  <= '0;
            collision_q  <= 1'b0;
        end else begin
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            btn_meta_q   <= btn_meta_d;
            btn_sync_q   <= btn_sync_d;
            db_q         <= db_d;
            db_dly_q     <= db_dly_d;
            for (int i = 0; i < int'(NB_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            switches_q   <= switches_d;
            load_pulse_q <= load_pulse_d;
            btn_level_q  <= btn_level_d;
            collision_q  <= collision_d;
        end
    end

    assign o_switches   = switches_q;
    assign o_load_pulse = load_pulse_q;
    assign o_btn_level  = btn_level_q;
    assign o_collision  = collision_q;

endmodule
